// File: rtl/mem_dbus_stage_pkg.sv
// Shared definitions for the MEM-stage data-bus block: access-op codes,
// FSM state codes, byte-select constants and op classification helpers.
package mem_dbus_stage_pkg;

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_LB   = 4'd1,
    OP_LBU  = 4'd2,
    OP_LH   = 4'd3,
    OP_LHU  = 4'd4,
    OP_LW   = 4'd5,
    OP_SB   = 4'd6,
    OP_SH   = 4'd7,
    OP_SW   = 4'd8,
    OP_LL   = 4'd9,
    OP_SC   = 4'd10
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_HOLD = 2'd2
  } mem_state_e;

  // Big-endian lanes: byte offset 0 sits in data[31:24].
  localparam logic [3:0] SEL_NONE = 4'b0000;
  localparam logic [3:0] SEL_B0   = 4'b1000;
  localparam logic [3:0] SEL_B1   = 4'b0100;
  localparam logic [3:0] SEL_B2   = 4'b0010;
  localparam logic [3:0] SEL_B3   = 4'b0001;
  localparam logic [3:0] SEL_H0   = 4'b1100;
  localparam logic [3:0] SEL_H1   = 4'b0011;
  localparam logic [3:0] SEL_W    = 4'b1111;

  function automatic logic is_load(mem_op_e op);
    return op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LL};
  endfunction

  function automatic logic is_store(mem_op_e op);
    return op inside {OP_SB, OP_SH, OP_SW, OP_SC};
  endfunction

endpackage

// File: rtl/mem_dbus_stage_if.sv
// Single-master Wishbone-style data bus between the MEM stage and memory.
interface mem_dbus_stage_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              dbus_cyc_o;
  logic              dbus_stb_o;
  logic              dbus_we_o;
  logic [ADDR_W-1:0] dbus_addr_o;
  logic [3:0]        dbus_sel_o;
  logic [DATA_W-1:0] dbus_data_o;
  logic              dbus_ack_i;
  logic [DATA_W-1:0] dbus_data_i;

  modport master (
    output dbus_cyc_o, dbus_stb_o, dbus_we_o, dbus_addr_o, dbus_sel_o, dbus_data_o,
    input  dbus_ack_i, dbus_data_i
  );

  modport slave (
    input  dbus_cyc_o, dbus_stb_o, dbus_we_o, dbus_addr_o, dbus_sel_o, dbus_data_o,
    output dbus_ack_i, dbus_data_i
  );
endinterface

// File: rtl/mem_dbus_stage_align.sv
// Combinational byte-lane logic: store select/data replication and
// load extraction with sign/zero extension (big-endian, 32-bit only).
module mem_align
  import mem_dbus_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  mem_op_e           op,
  input  logic [1:0]        lane,
  input  logic [DATA_W-1:0] sdata,
  input  logic [DATA_W-1:0] rdata,
  output logic [3:0]        sel,
  output logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] ldata
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    sel   = SEL_W;
    wdata = sdata;
    case (op)
      OP_LB, OP_LBU, OP_SB: begin
        case (lane)
          2'd0:    sel = SEL_B0;
          2'd1:    sel = SEL_B1;
          2'd2:    sel = SEL_B2;
          default: sel = SEL_B3;
        endcase
      end
      OP_LH, OP_LHU, OP_SH: sel = lane[1] ? SEL_H1 : SEL_H0;
      default:              sel = SEL_W;
    endcase
    case (op)
      OP_SB:   wdata = {4{sdata[7:0]}};
      OP_SH:   wdata = {2{sdata[15:0]}};
      default: wdata = sdata;
    endcase
  end

  // Misaligned halfwords simply use the lane picked by addr[1].
  always_comb begin
    rbyte = rdata[7:0];
    rhalf = lane[1] ? rdata[15:0] : rdata[31:16];
    ldata = rdata;
    case (lane)
      2'd0:    rbyte = rdata[31:24];
      2'd1:    rbyte = rdata[23:16];
      2'd2:    rbyte = rdata[15:8];
      default: rbyte = rdata[7:0];
    endcase
    case (op)
      OP_LB:   ldata = {{(DATA_W-8){rbyte[7]}}, rbyte};
      OP_LBU:  ldata = {{(DATA_W-8){1'b0}}, rbyte};
      OP_LH:   ldata = {{(DATA_W-16){rhalf[15]}}, rhalf};
      OP_LHU:  ldata = {{(DATA_W-16){1'b0}}, rhalf};
      default: ldata = rdata;
    endcase
  end

endmodule

// File: rtl/mem_dbus_stage.sv
// MEM pipeline stage: drives the data-bus handshake, aligns load/store data,
// resolves LL/SC against the forwarded LLbit and stalls the pipe while busy.
module mem_dbus_stage
  import mem_dbus_stage_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        ex_mem_op,
  input  logic [ADDR_W-1:0] ex_mem_addr,
  input  logic [DATA_W-1:0] ex_mem_sdata,
  input  logic [4:0]        ex_wd,
  input  logic              ex_wreg,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic [DATA_W-1:0] ex_hi,
  input  logic [DATA_W-1:0] ex_lo,
  input  logic              ex_whilo,
  input  logic              LLbit_i,
  input  logic              wb_LLbit_we,
  input  logic              wb_LLbit_value,
  input  logic [5:0]        stall,
  mem_dbus_stage_if.master  dbus,
  output logic              stallreq,
  output logic [4:0]        mem_wd,
  output logic              mem_wreg,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_hi,
  output logic [DATA_W-1:0] mem_lo,
  output logic              mem_whilo,
  output logic              mem_LLbit_we,
  output logic              mem_LLbit_value
);

  mem_op_e           op;
  mem_state_e        state;
  logic              eff_llbit;
  logic              access_req;
  logic              ack_now;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_src;
  logic [3:0]        a_sel;
  logic [DATA_W-1:0] a_wdata;
  logic [DATA_W-1:0] a_ldata;
  logic              cyc_q, stb_q, we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        sel_q;
  logic [DATA_W-1:0] data_q;
  logic              unused_stall;

  assign op           = mem_op_e'(ex_mem_op);
  assign unused_stall = ^{stall[5], stall[3:0]};
  assign eff_llbit    = wb_LLbit_we ? wb_LLbit_value : LLbit_i;
  // A store-conditional that has already lost its reservation never touches the bus.
  assign access_req   = (is_load(op) || is_store(op)) && !(op == OP_SC && !eff_llbit);
  assign ack_now      = (state == ST_BUSY) && dbus.dbus_ack_i;
  assign rdata_src    = ack_now ? dbus.dbus_data_i : rdata_q;

  mem_align #(.DATA_W(DATA_W)) u_align (
    .op    (op),
    .lane  (ex_mem_addr[1:0]),
    .sdata (ex_mem_sdata),
    .rdata (rdata_src),
    .sel   (a_sel),
    .wdata (a_wdata),
    .ldata (a_ldata)
  );

  // NOTE: state and bus registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      sel_q   <= SEL_NONE;
      data_q  <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (access_req) begin
            cyc_q  <= 1'b1;
            stb_q  <= 1'b1;
            we_q   <= is_store(op);
            addr_q <= {ex_mem_addr[ADDR_W-1:2], 2'b00};
            sel_q  <= a_sel;
            data_q <= a_wdata;
            state  <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (dbus.dbus_ack_i) begin
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= SEL_NONE;
            rdata_q <= dbus.dbus_data_i;
            state   <= stall[4] ? ST_HOLD : ST_IDLE;
          end
        end
        ST_HOLD: begin
          if (!stall[4]) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign dbus.dbus_cyc_o  = cyc_q;
  assign dbus.dbus_stb_o  = stb_q;
  assign dbus.dbus_we_o   = we_q;
  assign dbus.dbus_addr_o = addr_q;
  assign dbus.dbus_sel_o  = sel_q;
  assign dbus.dbus_data_o = data_q;

  always_comb begin
    stallreq        = 1'b0;
    mem_wd          = '0;
    mem_wreg        = 1'b0;
    mem_wdata       = '0;
    mem_hi          = '0;
    mem_lo          = '0;
    mem_whilo       = 1'b0;
    mem_LLbit_we    = 1'b0;
    mem_LLbit_value = 1'b0;
    if (!rst) begin
      mem_wd    = ex_wd;
      mem_wreg  = ex_wreg;
      mem_wdata = ex_wdata;
      mem_hi    = ex_hi;
      mem_lo    = ex_lo;
      mem_whilo = ex_whilo;
      case (state)
        ST_IDLE: stallreq = access_req;
        ST_BUSY: stallreq = !dbus.dbus_ack_i;
        default: stallreq = 1'b0;
      endcase
      if (is_load(op)) mem_wdata = a_ldata;
      if (op == OP_LL) begin
        mem_LLbit_we    = 1'b1;
        mem_LLbit_value = 1'b1;
      end
      if (op == OP_SC) begin
        mem_wdata       = DATA_W'(eff_llbit);
        mem_LLbit_we    = eff_llbit;
        mem_LLbit_value = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_dbus_stage.sv
// Self-checking bench for mem_dbus_stage: a transaction-level model checked
// every cycle, plus directed accesses with hand-computed expectations.
`timescale 1ns/1ps
module tb_mem_dbus_stage;
  import mem_dbus_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  ex_mem_op;
  logic [31:0] ex_mem_addr, ex_mem_sdata;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic [31:0] ex_wdata, ex_hi, ex_lo;
  logic        ex_whilo, LLbit_i, wb_LLbit_we, wb_LLbit_value;
  logic [5:0]  stall;
  logic        stallreq;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata, mem_hi, mem_lo;
  logic        mem_whilo, mem_LLbit_we, mem_LLbit_value;

  always #5 clk = ~clk;

  mem_dbus_stage_if #(.ADDR_W(32), .DATA_W(32)) dbus ();

  mem_dbus_stage #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .ex_mem_op       (ex_mem_op),
    .ex_mem_addr     (ex_mem_addr),
    .ex_mem_sdata    (ex_mem_sdata),
    .ex_wd           (ex_wd),
    .ex_wreg         (ex_wreg),
    .ex_wdata        (ex_wdata),
    .ex_hi           (ex_hi),
    .ex_lo           (ex_lo),
    .ex_whilo        (ex_whilo),
    .LLbit_i         (LLbit_i),
    .wb_LLbit_we     (wb_LLbit_we),
    .wb_LLbit_value  (wb_LLbit_value),
    .stall           (stall),
    .dbus            (dbus),
    .stallreq        (stallreq),
    .mem_wd          (mem_wd),
    .mem_wreg        (mem_wreg),
    .mem_wdata       (mem_wdata),
    .mem_hi          (mem_hi),
    .mem_lo          (mem_lo),
    .mem_whilo       (mem_whilo),
    .mem_LLbit_we    (mem_LLbit_we),
    .mem_LLbit_value (mem_LLbit_value)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  // ---------------- reference model (transaction level) ----------------
  function automatic bit tb_is_load(logic [3:0] o);
    return (o == OP_LB) || (o == OP_LBU) || (o == OP_LH) || (o == OP_LHU) || (o == OP_LW) || (o == OP_LL);
  endfunction

  function automatic bit tb_is_store(logic [3:0] o);
    return (o == OP_SB) || (o == OP_SH) || (o == OP_SW) || (o == OP_SC);
  endfunction

  function automatic logic [3:0] tb_sel(logic [3:0] o, logic [31:0] a);
    if (o == OP_LB || o == OP_LBU || o == OP_SB) return 4'b1000 >> a[1:0];
    if (o == OP_LH || o == OP_LHU || o == OP_SH) return a[1] ? 4'b0011 : 4'b1100;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] tb_store_data(logic [3:0] o, logic [31:0] s);
    if (o == OP_SB) return {4{s[7:0]}};
    if (o == OP_SH) return {2{s[15:0]}};
    return s;
  endfunction

  function automatic logic [31:0] tb_load_data(logic [3:0] o, logic [31:0] a, logic [31:0] rd);
    logic [31:0] b, h;
    b = (rd >> (8 * (3 - int'(a[1:0])))) & 32'hFF;
    h = (rd >> (a[1] ? 0 : 16)) & 32'hFFFF;
    case (o)
      OP_LB:   return b[7]  ? (b | 32'hFFFF_FF00) : b;
      OP_LBU:  return b;
      OP_LH:   return h[15] ? (h | 32'hFFFF_0000) : h;
      OP_LHU:  return h;
      default: return rd;
    endcase
  endfunction

  function automatic bit tb_eff_ll();
    return wb_LLbit_we ? wb_LLbit_value : LLbit_i;
  endfunction

  function automatic bit tb_wants_bus();
    return (tb_is_load(ex_mem_op) || tb_is_store(ex_mem_op)) && !(ex_mem_op == OP_SC && !tb_eff_ll());
  endfunction

  // m_open: a bus transaction is outstanding; m_served: the instruction in MEM
  // already completed its access and is merely being held by the pipeline.
  bit          m_init = 0;
  bit          m_open, m_served, m_we;
  logic [31:0] m_addr, m_data, m_rdata;
  logic [3:0]  m_sel;

  always @(posedge clk) begin
    if (rst) begin
      m_init   = 1;
      m_open   = 0;
      m_served = 0;
      m_rdata  = '0;
    end else if (m_init) begin
      if (m_open) begin
        if (dbus.dbus_ack_i) begin
          m_open   = 0;
          m_served = stall[4];
          m_rdata  = dbus.dbus_data_i;
        end
      end else if (m_served) begin
        if (!stall[4]) m_served = 0;
      end else if (tb_wants_bus()) begin
        m_open = 1;
        m_we   = tb_is_store(ex_mem_op);
        m_addr = ex_mem_addr & 32'hFFFF_FFFC;
        m_sel  = tb_sel(ex_mem_op, ex_mem_addr);
        m_data = tb_store_data(ex_mem_op, ex_mem_sdata);
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      logic        e_stall, e_llwe, e_llval;
      logic [31:0] e_wdata, rd;
      e_stall = !rst && (m_open ? !dbus.dbus_ack_i : (!m_served && tb_wants_bus()));
      check("cmp_stallreq", stallreq, e_stall);
      check("cmp_cyc", dbus.dbus_cyc_o, m_open);
      check("cmp_stb", dbus.dbus_stb_o, m_open);
      if (m_open) begin
        check("cmp_addr", dbus.dbus_addr_o, m_addr);
        check("cmp_sel", dbus.dbus_sel_o, m_sel);
        check("cmp_we", dbus.dbus_we_o, m_we);
        if (m_we) check("cmp_wdata_bus", dbus.dbus_data_o, m_data);
      end
      check("cmp_wd", mem_wd, rst ? 5'd0 : ex_wd);
      check("cmp_wreg", mem_wreg, rst ? 1'b0 : ex_wreg);
      check("cmp_hi", mem_hi, rst ? 32'd0 : ex_hi);
      check("cmp_lo", mem_lo, rst ? 32'd0 : ex_lo);
      check("cmp_whilo", mem_whilo, rst ? 1'b0 : ex_whilo);
      if (rst || !e_stall) begin
        rd      = (m_open && dbus.dbus_ack_i) ? dbus.dbus_data_i : m_rdata;
        e_wdata = ex_wdata;
        e_llwe  = 0;
        e_llval = 0;
        if (tb_is_load(ex_mem_op)) e_wdata = tb_load_data(ex_mem_op, ex_mem_addr, rd);
        if (ex_mem_op == OP_LL) begin e_llwe = 1; e_llval = 1; end
        if (ex_mem_op == OP_SC) begin
          e_wdata = tb_eff_ll() ? 32'd1 : 32'd0;
          e_llwe  = tb_eff_ll();
        end
        if (rst) begin e_wdata = 0; e_llwe = 0; e_llval = 0; end
        check("cmp_mem_wdata", mem_wdata, e_wdata);
        check("cmp_llbit_we", mem_LLbit_we, e_llwe);
        check("cmp_llbit_value", mem_LLbit_value, e_llval);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  typedef struct {
    int          stalls;
    bit          cyc_seen;
    bit          acked;
    logic [31:0] wdata, addr, data;
    logic [3:0]  sel;
    logic        we, llwe, llval;
  } res_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one instruction in MEM, acks wait_n cycles into BUSY, captures results.
  task automatic access(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                        input logic [31:0] rdat, input int wait_n, output res_t r);
    r = '{default: 0};
    ex_mem_op = op; ex_mem_addr = addr; ex_mem_sdata = sdata;
    dbus.dbus_ack_i = 1'b0;
    @(negedge clk);
    if (stallreq) begin
      r.stalls = 1;
      step();
      for (int n = 0; n < 64; n++) begin
        if (n == wait_n) begin dbus.dbus_ack_i = 1'b1; dbus.dbus_data_i = rdat; end
        @(negedge clk);
        if (dbus.dbus_cyc_o) begin
          r.cyc_seen = 1; r.addr = dbus.dbus_addr_o; r.sel = dbus.dbus_sel_o;
          r.we = dbus.dbus_we_o; r.data = dbus.dbus_data_o;
        end
        if (stallreq) r.stalls++;
        if (dbus.dbus_ack_i) begin
          r.acked = 1; r.wdata = mem_wdata; r.llwe = mem_LLbit_we; r.llval = mem_LLbit_value;
          break;
        end
        step();
      end
      if (!r.acked) check("access_timeout", 32'd0, 32'd1);
    end else begin
      r.cyc_seen = dbus.dbus_cyc_o;
      r.wdata = mem_wdata; r.llwe = mem_LLbit_we; r.llval = mem_LLbit_value;
    end
    step();
    dbus.dbus_ack_i = 1'b0; dbus.dbus_data_i = '0; ex_mem_op = OP_NONE;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    res_t r;
    rst = 1'b1; ex_mem_op = OP_NONE; ex_mem_addr = 32'h0; ex_mem_sdata = 32'h0;
    ex_wd = 5'd7; ex_wreg = 1'b1; ex_wdata = 32'h0000_1234; ex_hi = 32'hA5A5_0001; ex_lo = 32'h5A5A_0002;
    ex_whilo = 1'b1; LLbit_i = 1'b0; wb_LLbit_we = 1'b0; wb_LLbit_value = 1'b0; stall = 6'b0;
    dbus.dbus_ack_i = 1'b0; dbus.dbus_data_i = 32'h0;
    step(); step();
    @(negedge clk);
    check("rst_cyc", dbus.dbus_cyc_o, 0);
    check("rst_sel", dbus.dbus_sel_o, 0);
    check("rst_addr", dbus.dbus_addr_o, 0);
    check("rst_mem_wd", mem_wd, 0);
    check("rst_mem_hi", mem_hi, 0);
    check("rst_stallreq", stallreq, 0);
    step();
    rst = 1'b0;

    // LW, ack one cycle after stb rises
    access(OP_LW, 32'h100, 32'h0, 32'h1122_3344, 1, r);
    check("lw_stalls", r.stalls, 2);
    check("lw_wdata", r.wdata, 32'h1122_3344);
    check("lw_sel", r.sel, 4'b1111);
    check("lw_addr", r.addr, 32'h100);
    check("lw_we", r.we, 0);

    access(OP_LB, 32'h103, 32'h0, 32'h0000_00F0, 0, r);
    check("lb_sel", r.sel, 4'b0001);
    check("lb_wdata", r.wdata, 32'hFFFF_FFF0);
    check("lb_addr", r.addr, 32'h100);
    check("lb_stalls", r.stalls, 1);
    access(OP_LBU, 32'h103, 32'h0, 32'h0000_00F0, 0, r);
    check("lbu_wdata", r.wdata, 32'h0000_00F0);
    access(OP_LH, 32'h100, 32'h0, 32'h8001_7FFF, 0, r);
    check("lh_sel", r.sel, 4'b1100);
    check("lh_wdata", r.wdata, 32'hFFFF_8001);

    ex_wdata = 32'h0000_0AAA;
    access(OP_SH, 32'h202, 32'hABCD_1234, 32'h0, 0, r);
    check("sh_data", r.data, 32'h1234_1234);
    check("sh_sel", r.sel, 4'b0011);
    check("sh_we", r.we, 1);
    check("sh_addr", r.addr, 32'h200);
    check("sh_wdata", r.wdata, 32'h0000_0AAA);
    access(OP_SB, 32'h301, 32'h0000_00C3, 32'h0, 0, r);
    check("sb_data", r.data, 32'hC3C3_C3C3);
    check("sb_sel", r.sel, 4'b0100);

    // LL then SC with a reservation forwarded from WB
    LLbit_i = 1'b0; wb_LLbit_we = 1'b1; wb_LLbit_value = 1'b1;
    access(OP_LL, 32'h40, 32'h0, 32'h89AB_CDEF, 0, r);
    check("ll_wdata", r.wdata, 32'h89AB_CDEF);
    check("ll_llwe", r.llwe, 1);
    check("ll_llval", r.llval, 1);
    access(OP_SC, 32'h40, 32'h0000_0077, 32'h0, 0, r);
    check("sc_cyc", r.cyc_seen, 1);
    check("sc_we", r.we, 1);
    check("sc_data", r.data, 32'h0000_0077);
    check("sc_wdata", r.wdata, 32'd1);
    check("sc_llwe", r.llwe, 1);
    check("sc_llval", r.llval, 0);

    // SC with no reservation: no bus cycle, result 0
    wb_LLbit_we = 1'b0; LLbit_i = 1'b0;
    access(OP_SC, 32'h40, 32'h0000_0077, 32'h0, 0, r);
    check("scf_stalls", r.stalls, 0);
    check("scf_cyc", r.cyc_seen, 0);
    check("scf_wdata", r.wdata, 0);
    check("scf_llwe", r.llwe, 0);
    @(negedge clk);
    check("scf_cyc_after", dbus.dbus_cyc_o, 0);
    step();

    access(OP_LW, 32'h104, 32'h0, 32'h0BAD_F00D, 5, r);
    check("dly_stalls", r.stalls, 6);
    check("dly_wdata", r.wdata, 32'h0BAD_F00D);

    // Request under an external MEM hold, then HOLD keeps the latched data
    stall = 6'b010000;
    ex_mem_op = OP_LW; ex_mem_addr = 32'h108;
    @(negedge clk);
    check("hold_req_stall", stallreq, 1);
    step();
    dbus.dbus_ack_i = 1'b1; dbus.dbus_data_i = 32'hCAFE_F00D;
    @(negedge clk);
    check("hold_ack_wdata", mem_wdata, 32'hCAFE_F00D);
    step();
    dbus.dbus_ack_i = 1'b0; dbus.dbus_data_i = 32'h1234_5678;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("hold_cyc", dbus.dbus_cyc_o, 0);
      check("hold_stallreq", stallreq, 0);
      check("hold_wdata", mem_wdata, 32'hCAFE_F00D);
      step();
    end
    stall = 6'b0;
    step();
    ex_mem_op = OP_NONE;

    // Reset while BUSY: access abandoned, late ack ignored
    ex_mem_op = OP_LW; ex_mem_addr = 32'h10C;
    step();
    rst = 1'b1;
    @(negedge clk);
    check("rbusy_cyc_before", dbus.dbus_cyc_o, 1);
    check("rbusy_stallreq", stallreq, 0);
    check("rbusy_mem_wd", mem_wd, 0);
    check("rbusy_mem_wdata", mem_wdata, 0);
    step();
    rst = 1'b0; ex_mem_op = OP_NONE; ex_wdata = 32'h0000_5555;
    dbus.dbus_ack_i = 1'b1; dbus.dbus_data_i = 32'hDEAD_DEAD;
    @(negedge clk);
    check("rbusy_cyc_after", dbus.dbus_cyc_o, 0);
    check("rbusy_late_ack_stall", stallreq, 0);
    check("rbusy_late_ack_wdata", mem_wdata, 32'h0000_5555);
    step();
    dbus.dbus_ack_i = 1'b0;
    @(negedge clk);
    check("rbusy_idle_cyc", dbus.dbus_cyc_o, 0);
    step(); step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_dbus_stage.md
Name: mem_dbus_stage

Overview:
- Memory-access stage of the 5-stage pipeline. Sits between the ex_mem pipeline register and the mem_wb register.
- Decodes the load/store class of the instruction in MEM and drives a single-master Wishbone-style data-bus handshake.
- Aligns and extends load data, and handles LL/SC together with the LLbit forwarded from write-back.
- Raises stallreq to the pipeline controller while a bus access is outstanding, and emits the mem_* signals consumed by mem_wb.

Parameters:
- ADDR_W, 32, data-bus address width.
- DATA_W, 32, data-bus and register width; only 32 is supported.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous reset, active-high.
- ex_mem_op  in  4  access class; codes in shared defines (NONE, LB, LBU, LH, LHU, LW, SB, SH, SW, LL, SC).
- ex_mem_addr  in  32  effective address.
- ex_mem_sdata  in  32  store source register value.
- ex_wd  in  5  destination register address.
- ex_wreg  in  1  destination write enable.
- ex_wdata  in  32  ALU result, passed through for non-loads.
- ex_hi, ex_lo  in  32 each  HI/LO pass-through.
- ex_whilo  in  1  HI/LO write enable pass-through.
- LLbit_i  in  1  current LLbit register value.
- wb_LLbit_we, wb_LLbit_value  in  1 each  LLbit update in WB, forwarded.
- stall  in  6  pipeline stall vector; stall[4] is the MEM hold.
- dbus_ack_i  in  1  bus acknowledge.
- dbus_data_i  in  32  bus read data.
- dbus_cyc_o, dbus_stb_o, dbus_we_o  out  1 each  bus cycle, strobe and write.
- dbus_addr_o  out  32  bus address.
- dbus_sel_o  out  4  byte selects.
- dbus_data_o  out  32  bus write data.
- stallreq  out  1  request to freeze IF..MEM.
- mem_wd  out  5  to mem_wb.
- mem_wreg  out  1  to mem_wb.
- mem_wdata  out  32  to mem_wb.
- mem_hi, mem_lo  out  32 each  to mem_wb.
- mem_whilo  out  1  to mem_wb.
- mem_LLbit_we, mem_LLbit_value  out  1 each  to mem_wb.

Behaviour:
- Reset (rst=1 at an edge): FSM goes to IDLE and all registered bus outputs clear to 0. While rst=1, every mem_* output and stallreq is forced to 0.
- Reset mid-access: the access is abandoned, cyc/stb drop at that edge, and a late ack is ignored.
- Effective LLbit: wb_LLbit_we ? wb_LLbit_value : LLbit_i.
- Access required: any load/store op, except SC with effective LLbit=0.
- SC failing: no bus access, mem_wdata=0, LLbit unchanged (mem_LLbit_we=0).
- Big-endian byte lanes. The bus address is {addr[31:2],2'b00}.
  - Byte lanes: addr[1:0]=00 -> sel 1000, data[31:24]; 11 -> sel 0001.
  - Halfword: addr[1]=0 -> sel 1100; addr[1]=1 -> sel 0011.
  - Word/LL/SC: sel 1111.
  - Misaligned halfword/word uses the truncated lane without any exception.
- Store data replication: SB {4{b}}, SH {2{h}}, SW as-is.
- Load extension: LB/LH sign-extend, LBU/LHU zero-extend.
- FSM states IDLE, BUSY, HOLD:
  - IDLE: if access required, stallreq=1 combinationally. Next edge asserts cyc=stb=1, registers addr/sel/we/data, and moves to BUSY. Otherwise stallreq=0 and outputs pass through unchanged.
  - BUSY: cyc/stb held and stallreq=1 until dbus_ack_i.
    - In the ack cycle: stallreq=0, and load result comes combinationally from dbus_data_i. rdata is latched and cyc/stb/we/sel clear at the edge.
    - Next state: HOLD if stall[4]=1, else IDLE.
  - HOLD: stallreq=0 and outputs use latched rdata. Move to IDLE when stall[4]=0.
- Minimum access latency: 2 cycles, one IDLE request cycle plus one BUSY cycle with immediate ack.
- Loads: mem_wdata is the extended read data. LL also sets LLbit_we=1, LLbit_value=1.
- SC success: mem_wdata=1, LLbit_we=1, LLbit_value=0.
- Stores other than SC: mem_wdata passes ex_wdata; mem_wreg as input.
- HI/LO, wd and wreg always pass through unchanged.
- A request present in IDLE while stall[4]=1 from another source still starts the access.

Decomposition:
- Shared defines file: access-op codes, FSM state codes, byte-select constants.
- One sub-module, mem_align. It is purely combinational and contains:
  - store lane/select/data generation from op+addr+sdata;
  - load extraction and extension from op+addr+rdata.
- The FSM, LL/SC logic and the stallreq/bus registers stay in mem_dbus_stage.

Test Plan:
- LW addr 0x100, ack one cycle after stb rises, data 0x11223344.
  - stallreq=1 for 2 cycles.
  - mem_wdata=0x11223344, sel=1111.
- LB addr 0x103, data 0x000000F0 -> sel=0001, mem_wdata=0xFFFFFFF0. LBU on the same data -> 0x000000F0.
- SH addr 0x202, sdata 0xABCD1234 -> dbus_data_o=0x12341234, sel=0011, we=1, addr=0x200.
- LL addr 0x40 then SC addr 0x40 with LLbit_i=0 and wb_LLbit_we=1, wb_LLbit_value=1 (forwarded).
  - LL: LLbit_we=1, value=1.
  - SC: bus write occurs, mem_wdata=1, LLbit value 0.
- SC with effective LLbit=0 -> no cyc, stallreq=0, mem_wdata=0.
- Ack delayed 5 cycles, then a separate LW with rst pulsed while in BUSY.
  - Delayed ack: stallreq high throughout the wait.
  - rst in BUSY: cyc drops next edge, outputs 0, and a later ack has no effect.
